i2c_sec_tx: RTL and testbench



---
 rtl/i2c_sec_tx.sv | 193 +++++++++++++++++++
 tb/tb_i2c_sec_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sec_tx.sv
// i2c_sec_tx: I2C master write engine. Each accepted request writes one byte to a fixed
// slave register. The bus sequence is START, {DEV_ADDR,W}, reg_addr, wdata, STOP. A NACK
// in any ACK slot ends the transfer early with a STOP.
//
// Optional feature: define I2C_SEC_TX_CLK_STRETCH_EN to honour slave clock stretching
// (scl_i is read in quarter q1 of every data/ACK bit). When it is undefined, scl_i is unused.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle request strobe, accepted only in IDLE
//   reg_addr, wdata register address and data byte, latched on accept
//   busy            transaction in progress
//   done            one-cycle pulse at the end of a transaction
//   nack            last transaction saw a NACK (held until next accept)
//   scl_oe, sda_oe  open-drain enables (1 = pull line low)
//   sda_i, scl_i    pin readback
module i2c_sec_tx #(
    parameter int unsigned CLK_FREQ = 84_000_000,
    parameter int unsigned I2C_FREQ = 100_000,
    parameter logic [6:0]  DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic       scl_i
);

    localparam int unsigned QTR   = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned DIV_W = (QTR < 2) ? 1 : $clog2(QTR);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(QTR - 1);

    if (QTR < 2) begin : g_qtr_check
        $error("i2c_sec_tx: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StByte, StAck, StStop, StDone} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             nack_q, nack_d;

    logic       qtr_end;
    logic [7:0] cur_byte;

    assign qtr_end = (div_q == DIV_MAX);
    assign nack    = nack_q;

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = reg_addr_q;
            default: cur_byte = wdata_q;
        endcase
    end

`ifndef I2C_SEC_TX_CLK_STRETCH_EN
    logic unused_scl;
    assign unused_scl = scl_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            qtr_q      <= 2'd0;
            idx_q      <= 2'd0;
            bit_q      <= 3'd7;
            reg_addr_q <= 8'h00;
            wdata_q    <= 8'h00;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            idx_q      <= idx_d;
            bit_q      <= bit_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            nack_q     <= nack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        qtr_d      = qtr_q;
        idx_d      = idx_q;
        bit_d      = bit_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        nack_d     = nack_q;
        busy       = 1'b0;
        done       = 1'b0;
        scl_oe     = 1'b0;
        sda_oe     = 1'b0;

        // Quarter timebase, active in every bus phase.
        if (state_q inside {StStart, StByte, StAck, StStop}) begin
            busy = 1'b1;
            if (qtr_end) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    reg_addr_d = reg_addr;
                    wdata_d    = wdata;
                    nack_d     = 1'b0;
                    div_d      = '0;
                    qtr_d      = 2'd0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                sda_oe = (qtr_q != 2'd0);
                scl_oe = (qtr_q == 2'd3);
                if (qtr_end && qtr_q == 2'd3) begin
                    idx_d   = 2'd0;
                    bit_d   = 3'd7;
                    state_d = StByte;
                end
            end
            StByte: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                // SDA held for the whole bit so it only moves while SCL is low.
                sda_oe = ~cur_byte[bit_q];
                if (qtr_end && qtr_q == 2'd3) begin
                    if (bit_q == 3'd0) begin
                        state_d = StAck;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            StAck: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                if (qtr_q == 2'd2 && div_q == '0 && sda_i) begin
                    nack_d = 1'b1;
                end
                if (qtr_end && qtr_q == 2'd3) begin
                    if (nack_q || idx_q == 2'd2) begin
                        state_d = StStop;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        bit_d   = 3'd7;
                        state_d = StByte;
                    end
                end
            end
            StStop: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = (qtr_q <= 2'd1);
                if (qtr_end && qtr_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                div_d   = '0;
                qtr_d   = 2'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef I2C_SEC_TX_CLK_STRETCH_EN
        // Slave holding SCL low in the high phase freezes the timebase at q1 start.
        if ((state_q == StByte || state_q == StAck) && qtr_q == 2'd1 && !scl_i) begin
            div_d = '0;
            qtr_d = qtr_q;
        end
`endif
    end

endmodule

// File: tb/tb_i2c_sec_tx.sv
// Bench for i2c_sec_tx: open-drain bus with a byte-decoding slave model, expected
// transactions queued at issue time and checked by a monitor on each done pulse.
module tb_i2c_sec_tx;

    localparam int unsigned CLK_FREQ = 4_000_000;
    localparam int unsigned I2C_FREQ = 100_000;
    localparam int QTR      = 10;
    localparam int FULL_LAT = 116 * QTR + 1;
    localparam int NACK_LAT = 44 * QTR + 1;
    localparam int STRETCH  = 500;
    localparam int BOUND    = 200 * QTR + 2 * STRETCH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, nack, scl_oe, sda_oe;
    logic       scl_line, sda_line;
    logic       stretch = 1'b0;
    logic       sl_low = 1'b0;
    logic       slave_nack_addr = 1'b0;
    int         cyc = 0;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    // Slave model observations.
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         rx_cnt = 0;
    logic [7:0] rx [4];

    typedef struct {
        int          start_cyc;
        int          lat;
        logic        nk;
        int          nbytes;
        logic [23:0] bytes;
        int          starts;
    } exp_t;
    exp_t exp_q[$];

    assign scl_line = !scl_oe && !stretch;
    assign sda_line = !sda_oe && !sl_low;

    i2c_sec_tx #(
        .CLK_FREQ(CLK_FREQ),
        .I2C_FREQ(I2C_FREQ),
        .DEV_ADDR(7'h50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .reg_addr(reg_addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .nack    (nack),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .sda_i   (sda_line),
        .scl_i   (scl_line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic void push_exp(input int a, input int lat, input logic nk, input int nb,
                                     input logic [23:0] by, input int st);
        exp_t e;
        e.start_cyc = a;
        e.lat       = lat;
        e.nk        = nk;
        e.nbytes    = nb;
        e.bytes     = by;
        e.starts    = st;
        exp_q.push_back(e);
    endfunction

    // Decodes START/STOP and data bits at negedge; ACKs unless told to NACK the address.
    task automatic slave();
        logic       prev_scl = 1'b1;
        logic       prev_sda = 1'b1;
        logic [7:0] sh = 8'h00;
        int         sbit = 0;
        forever begin
            @(negedge clk);
            if (prev_scl && scl_line && prev_sda && !sda_line) begin
                start_cnt++;
                stop_cnt = 0;
                rx_cnt   = 0;
                sbit     = 0;
                sl_low   = 1'b0;
            end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
                stop_cnt++;
            end else if (!prev_scl && scl_line) begin
                if (sbit < 8) begin
                    sh = {sh[6:0], sda_line};
                    sbit++;
                    if (sbit == 8 && rx_cnt < 4) begin
                        rx[rx_cnt] = sh;
                        rx_cnt++;
                    end
                end else begin
                    sbit = 9;
                end
            end else if (prev_scl && !scl_line) begin
                if (sbit == 8) begin
                    sl_low = !(slave_nack_addr && rx_cnt == 1);
                end else if (sbit == 9) begin
                    sl_low = 1'b0;
                    sbit   = 0;
                end
            end
            prev_scl = scl_line;
            prev_sda = sda_line;
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   last_starts = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_latency", cyc - e.start_cyc, e.lat);
                    check("nack", int'(nack), int'(e.nk));
                    check("busy_at_done", int'(busy), 0);
                    check("start_conditions", start_cnt - last_starts, e.starts);
                    check("stop_conditions", stop_cnt, 1);
                    check("byte_count", rx_cnt, e.nbytes);
                    for (int i = 0; i < e.nbytes; i++) begin
                        check($sformatf("byte%0d", i), int'(rx[i]),
                              int'(e.bytes[23 - 8 * i -: 8]));
                    end
                end
                last_starts = start_cnt;
            end
        end
    endtask

    // Drives start at a negedge; returns that cycle number as the latency origin.
    task automatic issue(input logic [7:0] ra, input logic [7:0] wd, output int a);
        start    = 1'b1;
        reg_addr = ra;
        wdata    = wd;
        a        = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", int'(busy), 1);
        check("nack_cleared_on_accept", int'(nack), 0);
    endtask

    task automatic wait_done();
        int target = done_cnt + 1;
        int n = 0;
        while (done_cnt < target && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done_cnt >= target), 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int a;
        int act;
        fork
            slave();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: no outputs, no bus activity.
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || done || nack || scl_oe || sda_oe) act++;
        end
        check("idle_activity", act, 0);
        check("idle_busy", int'(busy), 0);
        check("idle_scl_oe", int'(scl_oe), 0);
        check("idle_sda_oe", int'(sda_oe), 0);
        check("idle_start_conds", start_cnt, 0);

        // Full ACKed write.
        issue(8'h00, 8'h37, a);
        push_exp(a, FULL_LAT, 1'b0, 3, 24'hA0_00_37, 1);
        wait_done();

        // Address NACK: one byte on the bus, early STOP.
        slave_nack_addr = 1'b1;
        issue(8'h10, 8'h99, a);
        push_exp(a, NACK_LAT, 1'b1, 1, 24'hA0_00_00, 1);
        wait_done();
        slave_nack_addr = 1'b0;
        repeat (20) @(negedge clk);
        check("nack_held", int'(nack), 1);

        // Second start 1000 clocks in is ignored.
        issue(8'h12, 8'h34, a);
        push_exp(a, FULL_LAT, 1'b0, 3, 24'hA0_12_34, 1);
        while (cyc - a < 1000) @(negedge clk);
        start    = 1'b1;
        reg_addr = 8'h56;
        wdata    = 8'h78;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (QTR * 8) @(negedge clk);
        check("ignored_start_dones", done_cnt, 3);
        check("ignored_start_idle", int'(busy), 0);

        // Reset during wdata bit 3 (q0: SCL low, SDA low since bit 3 of 0xA5 is 0).
        issue(8'h5A, 8'hA5, a);
        while (cyc - a < 92 * QTR + 3) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_scl_oe", int'(scl_oe), 1);
        check("pre_reset_sda_oe", int'(sda_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_scl_oe", int'(scl_oe), 0);
        check("reset_sda_oe", int'(sda_oe), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (QTR * 4) @(negedge clk);
        issue(8'h5A, 8'hC3, a);
        push_exp(a, FULL_LAT, 1'b0, 3, 24'hA0_5A_C3, 2);
        wait_done();

        // Stretch in ACK of byte 1 (q1 starts at quarter 73) when enabled.
        issue(8'h01, 8'hFF, a);
`ifdef I2C_SEC_TX_CLK_STRETCH_EN
        push_exp(a, FULL_LAT + STRETCH, 1'b0, 3, 24'hA0_01_FF, 1);
        while (cyc - a < 73 * QTR + 1) @(negedge clk);
        stretch = 1'b1;
        while (cyc - a < 73 * QTR + 1 + STRETCH) @(negedge clk);
        stretch = 1'b0;
`else
        push_exp(a, FULL_LAT, 1'b0, 3, 24'hA0_01_FF, 1);
`endif
        wait_done();

        check("total_dones", done_cnt, 5);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
